// File: rtl/sram_if.sv
// Signal bundle for the sram word port (addr/en/din/dout).
// sram keeps its plain positional-compatible ports; this bundle is how
// newer code wires a master to it, e.g. .addr(bus.addr), .dout(bus.dout).
interface sram_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] addr;
  logic              en;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (output addr, output en, output din, input  dout);
  modport slave  (input  addr, input  en, input  din, output dout);
endinterface

// File: rtl/sram.sv
// Single-port synchronous SRAM with registered read data.
// Configuration macro: SRAM_WRITE_FIRST_EN
//   defined   -> same-address read during write returns din (write-first)
//   undefined -> same-address read during write returns old data (read-first)
// Reads happen every cycle; out-of-range addresses read 0 and never write.
// Reset clears dout asynchronously and blocks writes; the array is kept.
module sram #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  input  logic              reset
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  // Zero at time 0 so untouched words read as 0; never cleared by reset.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_d;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              wr_en;

  // Extra zero MSB keeps the compare correct when DEPTH == 2**ADDR_W.
  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign idx      = addr[IDX_W-1:0];
  assign wr_en    = en && in_range && !reset;

  // Next read data: bypass ordering chosen at build time.
  always_comb begin
    dout_d = '0;
    if (in_range) begin
`ifdef SRAM_WRITE_FIRST_EN
      if (en) begin
        dout_d = din;
      end else begin
        dout_d = mem_q[idx];
      end
`else
      dout_d = mem_q[idx];
`endif
    end
  end

  // Array write; reset sampled at the edge discards the write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx] <= din;
    end
  end

  // Read data register, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_sram.sv
// Randomised self-checking bench for sram against an array reference model.
module tb_sram;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int DEP  = 1024;
  localparam int SAW  = 3;
  localparam int SDEP = 6;
`ifdef SRAM_WRITE_FIRST_EN
  localparam bit WF = 1'b1;
`else
  localparam bit WF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_if #(.ADDR_W(AW),  .DATA_W(DW)) bus ();
  sram_if #(.ADDR_W(SAW), .DATA_W(DW)) sbus ();

  sram #(.ADDR_W(AW), .DEPTH(DEP), .DATA_W(DW)) dut (
    .clk(clk), .addr(bus.addr), .en(bus.en), .din(bus.din),
    .dout(bus.dout), .reset(rst)
  );

  sram #(.ADDR_W(SAW), .DEPTH(SDEP), .DATA_W(DW)) sdut (
    .clk(clk), .addr(sbus.addr), .en(sbus.en), .din(sbus.din),
    .dout(sbus.dout), .reset(rst)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [DW-1:0] ref_mem   [DEP];
  logic [DW-1:0] ref_small [SDEP];

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  // One cycle on the large instance; inputs change 1 unit after an edge.
  task automatic step(input string tag, input int a, input bit e,
                      input logic [DW-1:0] d);
    logic [DW-1:0] exp;
    bus.addr = AW'(a);
    bus.en   = e;
    bus.din  = d;
    exp = '0;
    if (!rst && a < DEP) exp = (WF && e) ? d : ref_mem[a];
    if (!rst && e && a < DEP) ref_mem[a] = d;
    @(posedge clk);
    #1;
    check(tag, bus.dout, exp);
  endtask

  // One cycle on the small (DEPTH=6) instance.
  task automatic step_s(input string tag, input int a, input bit e,
                        input logic [DW-1:0] d);
    logic [DW-1:0] exp;
    sbus.addr = SAW'(a);
    sbus.en   = e;
    sbus.din  = d;
    exp = '0;
    if (!rst && a < SDEP) exp = (WF && e) ? d : ref_small[a];
    if (!rst && e && a < SDEP) ref_small[a] = d;
    @(posedge clk);
    #1;
    check(tag, sbus.dout, exp);
  endtask

  initial begin
    foreach (ref_mem[i])   ref_mem[i]   = '0;
    foreach (ref_small[i]) ref_small[i] = '0;
    bus.addr = '0;  bus.en = 1'b0;  bus.din = '0;
    sbus.addr = '0; sbus.en = 1'b0; sbus.din = '0;

    #1;
    check("reset_dout", bus.dout, '0);
    check("reset_dout_s", sbus.dout, '0);

    // Reset held 20 cycles; write attempts during reset must be dropped.
    for (int i = 0; i < 20; i++) step("rst_hold", 5, 1'b1, 32'hDEAD_BEEF);
    rst = 1'b0;

    step("w5", 5, 1'b1, 32'h0000_1234);
    step("r5", 5, 1'b0, '0);
    step("uninit", 900, 1'b0, '0);

    // Write, then assert reset between edges.
    step("w3", 3, 1'b1, 32'hFFFF_FF00);
    rst = 1'b1;
    #1;
    check("async_rst", bus.dout, '0);
    for (int i = 0; i < 3; i++) step("rst_wr", 3, 1'b1, 32'h0000_0000);
    rst = 1'b0;
    step("r3", 3, 1'b0, '0);
    step("r3b", 3, 1'b0, '0);

    // Read-during-write ordering.
    step("w7", 7, 1'b1, 32'h11);
    step("rdw7", 7, 1'b1, 32'h55);
    step("r7", 7, 1'b0, '0);

    // Streaming writes then reads, one per cycle.
    for (int i = 0; i < 10; i++) step("stream_w", i, 1'b1, 32'(100 + i));
    for (int i = 0; i < 10; i++) step("stream_r", i, 1'b0, '0);

    // Random traffic with occasional single-cycle reset pulses.
    for (int i = 0; i < 400; i++) begin
      int a;
      rst = ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEP - 1))
                                       : int'($urandom_range(0, 15));
      step("rand", a, 1'($urandom_range(0, 1)), $urandom);
    end
    rst = 1'b0;
    step("rand_tail", 0, 1'b0, '0);

    // Small instance: addresses 6 and 7 are out of range.
    step_s("s_w6", 6, 1'b1, 32'hAA);
    step_s("s_r6", 6, 1'b0, '0);
    step_s("s_r0", 0, 1'b0, '0);
    step_s("s_w7", 7, 1'b1, 32'hBB);
    step_s("s_r7", 7, 1'b0, '0);
    for (int i = 0; i < 120; i++) begin
      step_s("s_rand", int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sram.md
SRAM -- requirements
Module: sram

Interface
REQ-001 The module SHALL declare parameter ADDR_W, default 10, meaning address port width in bits; it is the first positional parameter.
REQ-002 The module SHALL declare parameter DEPTH, default 1024, meaning number of stored words (legal 1..2^ADDR_W); it is the second positional parameter.
REQ-003 The module SHALL declare parameter DATA_W, default 32, meaning word width in bits.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 addr  input  ADDR_W  word address for both read and write; upper bits of a wider driver are discarded.
REQ-007 en  input  1  write enable; 1 = write din to addr at the clock edge, 0 = no write.
REQ-008 din  input  DATA_W  write data.
REQ-009 dout  output  DATA_W  registered read data, two's-complement signed interpretation by the consumer.
REQ-010 The port order SHALL be clk, addr, en, din, dout, reset, so that positional instantiation (clk, addr, en, din, dout) remains valid.

Function
REQ-011 Storage SHALL be an array of DEPTH words of DATA_W bits, indexed 0..DEPTH-1.
REQ-012 On every rising clk edge with reset low and addr < DEPTH, dout SHALL load mem[addr]: read latency is exactly one cycle, and reads occur every cycle regardless of en.
REQ-013 On a rising edge with en=1, reset low and addr < DEPTH, mem[addr] SHALL take din.
REQ-014 Writes with addr >= DEPTH SHALL be ignored; reads with addr >= DEPTH SHALL load dout with 0.
REQ-015 Back-to-back accesses to different addresses on consecutive cycles SHALL be supported with no stall, one result per cycle.
REQ-016 Data SHALL be stored and returned bit-exact, with no sign extension or truncation.
REQ-017 Read-during-write to the same address SHALL follow the ordering selected in Configuration.
REQ-018 Uninitialised locations SHALL read as 0 in simulation (array zero-initialised at time 0); there is no reset clearing of the array.

Reset
REQ-019 While reset is high, dout SHALL be 0 asynchronously, and writes SHALL be suppressed.
REQ-020 Memory contents SHALL be preserved across reset.
REQ-021 On the first rising edge after reset deasserts, normal read/write behaviour SHALL resume with dout = mem[addr] one cycle later.
REQ-022 If reset asserts in the same cycle as a write, the write SHALL be discarded.

Configuration
REQ-023 Macro SRAM_WRITE_FIRST_EN SHALL select the read-during-write ordering.
REQ-024 With SRAM_WRITE_FIRST_EN defined: same-address read during write SHALL return din (write-first).
REQ-025 Without SRAM_WRITE_FIRST_EN: same-address read during write SHALL return the old contents (read-first).

Verification
REQ-026 Reset high for 20 cycles, then write 0x0000_1234 at addr 5, next cycle read addr 5 with en=0 -> dout=0x0000_1234 exactly one edge after addr is applied.
REQ-027 Write 0xFFFF_FF00 at addr 3, then assert reset mid-stream and read addr 3 after release -> dout=0 during reset, then 0xFFFF_FF00.
REQ-028 ADDR_W=3, DEPTH=6: write 0xAA at addr 6, then read addr 6 and addr 0 -> dout=0 for both (addr 0 unchanged at 0).
REQ-029 Same-address write 0x55 over old 0x11 at addr 7 -> dout=0x11 without the macro; dout=0x55 with SRAM_WRITE_FIRST_EN.
REQ-030 Streaming: write addr 0..9 with values 100..109 (en=1), then read 0..9 on consecutive cycles -> dout = 100..109 in order, each one cycle late.
